// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one full-subtractor cell
module serial_subtractor #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] sayi1,
    input  logic [WIDTH-1:0] sayi2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   fark
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             bout;
    logic [WIDTH:0]   r_ext;

    // Full-subtractor cell on the current LSBs; r_ext[WIDTH:1] is the result shifted right with d in at the top
    always_comb begin
        d     = a_sr[0] ^ b_sr[0] ^ borrow;
        bout  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
        r_ext = {d, r_sr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            fark   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= sayi1;
                        b_sr   <= sayi2;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    r_sr   <= r_ext[WIDTH:1];
                    borrow <= bout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        fark  <= {bout, r_ext[WIDTH:1]};
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (WIDTH=3 and WIDTH=8)
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst;
    logic       start3, start8;
    logic [2:0] a3, b3;
    logic [7:0] a8, b8;
    logic       busy3, done3, busy8, done8;
    logic [3:0] fark3;
    logic [8:0] fark8;

    int checks = 0;
    int errors = 0;
    logic [3:0] last3 = '0;

    serial_subtractor #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .sayi1(a3), .sayi2(b3),
        .busy(busy3), .done(done3), .fark(fark3)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sayi1(a8), .sayi2(b8),
        .busy(busy8), .done(done8), .fark(fark8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one WIDTH=3 operation; inputs driven on negedge, outputs sampled on negedge
    task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic [3:0] exp, input string tag);
        int n;
        int busy_cnt;
        @(negedge clk);
        a3 = a; b3 = b; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        a3 = ~a; b3 = ~b;
        n = 0;
        busy_cnt = 0;
        while (!done3 && n < 12) begin
            if (busy3) busy_cnt++;
            if (n == 1) check({tag, "_hold"}, 32'(fark3), 32'(last3));
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, 3);
        check({tag, "_busycyc"}, busy_cnt, 3);
        check({tag, "_fark"}, 32'(fark3), 32'(exp));
        check({tag, "_busy_end"}, 32'(busy3), 0);
        last3 = exp;
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done3), 0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp, input string tag);
        int n;
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, 8);
        check({tag, "_fark"}, 32'(fark8), 32'(exp));
    endtask

    initial begin
        int dn;
        int n;
        logic [7:0] ra, rb;
        rst = 1'b1; start3 = 1'b0; start8 = 1'b0;
        a3 = '0; b3 = '0; a8 = '0; b8 = '0;
        @(negedge clk); @(negedge clk);
        check("rst_busy", 32'(busy3), 0);
        check("rst_done", 32'(done3), 0);
        check("rst_fark", 32'(fark3), 0);
        check("rst_fark8", 32'(fark8), 0);
        rst = 1'b0;

        op3(3'd5, 3'd3, 4'b0010, "5m3");
        op3(3'd3, 3'd5, 4'b1110, "3m5");
        op3(3'd0, 3'd7, 4'b1001, "0m7");
        op3(3'd7, 3'd7, 4'b0000, "7m7");

        // start while busy is ignored
        @(negedge clk);
        a3 = 3'd6; b3 = 3'd1; start3 = 1'b1;
        @(negedge clk);
        a3 = 3'd2; b3 = 3'd4;
        @(negedge clk);
        start3 = 1'b0; a3 = 3'd0; b3 = 3'd7;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (done3) begin
                dn++;
                check("ign_fark", 32'(fark3), 32'(4'b0101));
            end
            @(negedge clk);
        end
        check("ign_ndone", dn, 1);
        last3 = 4'b0101;

        // back-to-back: start held through the done cycle
        @(negedge clk);
        a3 = 3'd4; b3 = 3'd1; start3 = 1'b1;
        @(negedge clk);
        a3 = 3'd1; b3 = 3'd4;
        for (n = 0; n < 10; n++) begin
            if (n == 4) start3 = 1'b0;
            if (n == 3) begin
                check("b2b_d1", 32'(done3), 1);
                check("b2b_f1", 32'(fark3), 32'(4'b0011));
            end else if (n == 7) begin
                check("b2b_d2", 32'(done3), 1);
                check("b2b_f2", 32'(fark3), 32'(4'b1101));
            end else if (done3) begin
                check("b2b_extra", n, 99);
            end
            @(negedge clk);
        end

        // reset mid-operation
        a3 = 3'd7; b3 = 3'd2; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_busy", 32'(busy3), 0);
        check("mid_done", 32'(done3), 0);
        check("mid_fark", 32'(fark3), 0);
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            if (done3) dn++;
            @(negedge clk);
        end
        check("mid_nodone", dn, 0);
        last3 = 4'b0000;
        op3(3'd7, 3'd2, 4'b0101, "post_rst");

        // exhaustive WIDTH=3 against modular difference
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                op3(3'(a), 3'(b), 4'(a - b), "exh");
            end
        end

        op8(8'd200, 8'd100, 9'h064, "w8_200m100");
        op8(8'd100, 8'd200, 9'h19C, "w8_100m200");
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            op8(ra, rb, 9'({1'b0, ra} - {1'b0, rb}), "w8_rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
